pattern_buffer: RTL and testbench
=================================

# pattern_buffer

Pattern memory for the synthetic FRB injector.
- Write side: accepts a valid/ready sample stream and fills the memory from address 0 up to 2^ADDR_SIZE-1.
- Read side: answers the decimated address/address-valid stream from the playback address generator with one sample per valid address.
- Position in the design: sits between the pattern-upload path and the injection adder, as the responder end of the playback address interface.

## Interface
- ADDR_SIZE, 8, memory depth is 2^ADDR_SIZE words
- DATA_WIDTH, 16, sample width in bits
- clk  in  1  single clock for the whole block
- rst_n  in  1  reset, asynchronous, active-low
- wr_start  in  1  single-cycle pulse: restart the load at address 0
- din  in  DATA_WIDTH  sample to store
- din_valid  in  1  din is valid
- din_ready  out  1  block accepts din this cycle
- wr_count  out  ADDR_SIZE+1  number of samples stored since the last wr_start
- loaded  out  1  memory completely filled
- rd_addr  in  ADDR_SIZE  playback address
- rd_addr_valid  in  1  rd_addr is valid; one read per asserted cycle
- dout  out  DATA_WIDTH  sample read from memory
- dout_valid  out  1  dout is valid
- rd_early  out  1  sticky: a read arrived while loaded=0

## Operation
- FSM states: IDLE, LOAD, FULL. Reset state is IDLE.
- IDLE:
  - din_ready=0.
  - wr_start -> LOAD, write pointer=0, wr_count=0.
- LOAD:
  - din_ready = ~wr_start (combinational).
  - A beat is accepted when din_valid & din_ready: mem[wr_ptr] <= din, wr_ptr++, wr_count++.
  - Accepting the beat at wr_ptr=2^ADDR_SIZE-1 -> FULL, loaded=1 on the next cycle, wr_count=2^ADDR_SIZE.
- FULL:
  - din_ready=0. The pointer never wraps.
  - wr_start -> LOAD, with loaded, wr_count, wr_ptr and rd_early all cleared.
- wr_start in LOAD: restarts at address 0. The beat offered that cycle is not accepted, and wr_count clears.
- Read path:
  - Every rd_addr_valid cycle produces exactly one dout_valid pulse carrying mem[rd_addr], in every state.
  - Back-to-back valid addresses give back-to-back outputs, in order.
- Read and write to the same address in the same cycle: read-first, so dout returns the old contents.
- dout holds its last value while dout_valid=0.
- rd_early is set by any rd_addr_valid while loaded=0. It is cleared only by wr_start or reset.
- Reset values: din_ready=0, wr_count=0, loaded=0, dout=0, dout_valid=0, rd_early=0. Memory contents are not reset.
- Reset asserted mid-load: the block returns to IDLE immediately, and any read in flight is dropped (dout_valid=0).

## Timing
- din_ready depends only on the current state and wr_start; there is no path from din_valid to din_ready.
- A write accepted at edge N is readable by a read issued at edge N+1.
- loaded rises one cycle after the final beat is accepted.
- Read latency without the macro: rd_addr_valid at edge N -> dout/dout_valid at edge N+1.
- Read latency with the macro: dout/dout_valid at edge N+2.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- PATTERN_BUFFER_DOUT_REG_EN
  - Defined: adds an output register stage after the RAM read, giving read latency 2. dout_valid is delayed by the same stage and the reset values are unchanged.
  - Undefined: read latency 1.
- Write-side behaviour is identical in both builds.

## Structure
- Package pattern_buffer_pkg holds:
  - the state enum {IDLE, LOAD, FULL};
  - the read-latency constant, derived from the macro, for bench use.
- Sub-module pattern_ram: simple dual-port RAM with one write port and one read port, read-first, 1-cycle registered read, no reset on the array. It maps to block RAM.
- The FSM, pointer, counters and the valid pipeline live in the top module.

## Test plan
- Full load and readback: wr_start, then 256 beats with din=index. Expect loaded=1 one cycle after the last beat and wr_count=256. Then read addr 5, then addr 255: dout=5, then dout=255, each after the configured latency with dout_valid high.
- No accept outside LOAD: drive din_valid=1 in IDLE and in FULL for 10 cycles -> din_ready stays 0 and wr_count is unchanged. In FULL, a beat with din=0xFFFF does not overwrite address 0.
- Restart mid-load: after 100 beats, pulse wr_start with din_valid=1 -> that beat is not accepted and wr_count=0. The next beat lands at address 0.
- Early-read and collision:
  - Read addr 3 while loaded=0 -> rd_early=1 and dout_valid is still produced. rd_early clears on the next wr_start.
  - Write 0x1234 and read the same address in the same cycle -> dout shows the old value; a read on the next cycle returns 0x1234.
- Reset mid-operation: assert rst_n low during a load at count 50 with a read in flight -> all outputs go to their reset values immediately and no dout_valid pulse appears. After release the FSM is in IDLE.
- Streaming read: 256 consecutive rd_addr_valid cycles with addresses 0..255 on a loaded buffer -> 256 contiguous dout_valid cycles with dout=0..255.

Source files
------------

// File: rtl/pattern_buffer_pkg.sv
// Shared types and build constants for the FRB injector pattern buffer.
// Read latency follows PATTERN_BUFFER_DOUT_REG_EN (output register stage).
package pattern_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

`ifdef PATTERN_BUFFER_DOUT_REG_EN
   localparam int unsigned RD_LATENCY = 2;
`else
   localparam int unsigned RD_LATENCY = 1;
`endif

endpackage

// File: rtl/pattern_ram.sv
// Simple dual-port pattern RAM: one write port, one read-first registered read port.
// Only the read data register is reset; the array maps to block RAM.
module pattern_ram #(
   parameter int unsigned ADDR_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_we,
   input  logic [ADDR_SIZE-1:0]  i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_SIZE-1:0]  i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2**ADDR_SIZE;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Non-blocking read of the array gives read-first on a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pattern_buffer.sv
// Pattern memory for the synthetic FRB injector: sequential load, random-access playback.
// Define PATTERN_BUFFER_DOUT_REG_EN to add an output register stage (read latency 2).
module pattern_buffer
   import pattern_buffer_pkg::*;
#(
   parameter int unsigned ADDR_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_start,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [ADDR_SIZE:0]    wr_count,
   output logic                  loaded,
   input  logic [ADDR_SIZE-1:0]  rd_addr,
   input  logic                  rd_addr_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  rd_early
);

   state_t                r_state;
   logic [ADDR_SIZE-1:0]  r_wr_ptr;
   logic [ADDR_SIZE:0]    r_wr_count;
   logic                  r_loaded;
   logic                  r_rd_early;
   logic                  r_rd_vld1;
   logic                  w_wr_en;
   logic [DATA_WIDTH-1:0] w_ram_q;

   // Ready never looks at din_valid, so there is no valid->ready path.
   assign din_ready = (r_state == LOAD) && !wr_start;
   assign w_wr_en   = din_valid && din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_wr_count <= '0;
         r_loaded   <= 1'b0;
         r_rd_early <= 1'b0;
      end else begin
         // Any wr_start clears the flag; a read seen while unloaded sets it.
         r_rd_early <= (r_rd_early && !wr_start) || (rd_addr_valid && !r_loaded);
         case (r_state)
            IDLE: begin
               if (wr_start) begin
                  r_state    <= LOAD;
                  r_wr_ptr   <= '0;
                  r_wr_count <= '0;
               end
            end
            LOAD: begin
               if (wr_start) begin
                  r_wr_ptr   <= '0;
                  r_wr_count <= '0;
               end else if (w_wr_en) begin
                  r_wr_ptr   <= r_wr_ptr + ADDR_SIZE'(1);
                  r_wr_count <= r_wr_count + (ADDR_SIZE+1)'(1);
                  if (&r_wr_ptr) begin
                     r_state  <= FULL;
                     r_loaded <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (wr_start) begin
                  r_state    <= LOAD;
                  r_wr_ptr   <= '0;
                  r_wr_count <= '0;
                  r_loaded   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   pattern_ram #(
      .ADDR_SIZE  (ADDR_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata (din),
      .i_re    (rd_addr_valid),
      .i_raddr (rd_addr),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_vld1 <= 1'b0;
      else        r_rd_vld1 <= rd_addr_valid;
   end

`ifdef PATTERN_BUFFER_DOUT_REG_EN
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_rd_vld2;

   // Extra stage only loads on a valid read so dout holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout    <= '0;
         r_rd_vld2 <= 1'b0;
      end else begin
         r_rd_vld2 <= r_rd_vld1;
         if (r_rd_vld1) r_dout <= w_ram_q;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_rd_vld2;
`else
   assign dout       = w_ram_q;
   assign dout_valid = r_rd_vld1;
`endif

   assign wr_count = r_wr_count;
   assign loaded   = r_loaded;
   assign rd_early = r_rd_early;

endmodule

// File: tb/tb_pattern_buffer.sv
// Directed bench for pattern_buffer: behavioural model plus per-cycle compare process.
module tb_pattern_buffer;

   localparam int LAT = int'(pattern_buffer_pkg::RD_LATENCY);

   logic        clk;
   logic        rst_n;
   logic        wr_start;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [8:0]  wr_count;
   logic        loaded;
   logic [7:0]  rd_addr;
   logic        rd_addr_valid;
   logic [15:0] dout;
   logic        dout_valid;
   logic        rd_early;

   int checks = 0;
   int errors = 0;

   pattern_buffer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_start      (wr_start),
      .din           (din),
      .din_valid     (din_valid),
      .din_ready     (din_ready),
      .wr_count      (wr_count),
      .loaded        (loaded),
      .rd_addr       (rd_addr),
      .rd_addr_valid (rd_addr_valid),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .rd_early      (rd_early)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: 0 = not loading, 1 = loading, 2 = full; m_cnt is both count and next address.
   int  m_mode;
   int  m_cnt;
   bit  m_loaded;
   bit  m_early;
   bit  m_dv;
   int  m_dout;
   bit  m_dkn;
   int  cyc;
   int  mem [256];
   bit  known [256];
   int  q_due [$];
   int  q_data [$];
   bit  q_known [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_loaded = 0; m_early = 0;
      m_dv = 0; m_dout = 0; m_dkn = 1;
      q_due.delete(); q_data.delete(); q_known.delete();
   endtask

   // Advance the model across the next rising edge using the inputs now applied.
   task automatic model_step();
      bit acc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      cyc++;
      if (rd_addr_valid) begin
         q_due.push_back(cyc + LAT - 1);
         q_data.push_back(mem[rd_addr]);
         q_known.push_back(known[rd_addr]);
      end
      m_dv = 0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         m_dv   = 1;
         m_dout = q_data.pop_front();
         m_dkn  = q_known.pop_front();
         void'(q_due.pop_front());
      end
      m_early = (wr_start ? 1'b0 : m_early) | (rd_addr_valid && !m_loaded);
      acc = (m_mode == 1) && !wr_start && din_valid;
      if (wr_start) begin
         m_mode = 1; m_cnt = 0; m_loaded = 0;
      end else if (acc) begin
         mem[m_cnt] = int'(din);
         known[m_cnt] = 1;
         m_cnt++;
         if (m_cnt == 256) begin
            m_mode = 2; m_loaded = 1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      chk("din_ready", int'(din_ready), int'(m_mode == 1 && !wr_start));
      chk("wr_count", int'(wr_count), m_cnt);
      chk("loaded", int'(loaded), int'(m_loaded));
      chk("rd_early", int'(rd_early), int'(m_early));
      chk("dout_valid", int'(dout_valid), int'(m_dv));
      if (m_dkn) chk("dout", int'(dout), m_dout);
   end

   task automatic rd_check(input int a, input int exp, input string name);
      rd_addr = 8'(a);
      rd_addr_valid = 1'b1;
      tick();
      rd_addr_valid = 1'b0;
      repeat (LAT - 1) tick();
      chk({name, "_dv"}, int'(dout_valid), 1);
      chk(name, int'(dout), exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin mem[i] = 0; known[i] = 0; end
      cyc = 0;
      rst_n = 1'b0; wr_start = 1'b0; din = '0; din_valid = 1'b0;
      rd_addr = '0; rd_addr_valid = 1'b0;
      model_reset();
      repeat (3) tick();
      chk("rst_dout", int'(dout), 0);
      chk("rst_dout_valid", int'(dout_valid), 0);
      chk("rst_wr_count", int'(wr_count), 0);
      chk("rst_loaded", int'(loaded), 0);
      chk("rst_rd_early", int'(rd_early), 0);
      chk("rst_din_ready", int'(din_ready), 0);
      rst_n = 1'b1;

      // No accept while idle
      din = 16'hAAAA; din_valid = 1'b1;
      repeat (10) tick();
      chk("idle_cnt", int'(wr_count), 0);
      chk("idle_ready", int'(din_ready), 0);

      // Start a load; the beat offered with wr_start is dropped; early read of addr 3
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      chk("start_cnt", int'(wr_count), 0);
      rd_addr = 8'd3;
      for (int i = 0; i < 100; i++) begin
         din = 16'(i);
         rd_addr_valid = (i == 10);
         tick();
      end
      rd_addr_valid = 1'b0;
      chk("cnt100", int'(wr_count), 100);
      chk("early_set", int'(rd_early), 1);

      // Restart mid-load
      wr_start = 1'b1; din = 16'h7777; tick(); wr_start = 1'b0;
      chk("restart_cnt", int'(wr_count), 0);
      chk("early_clr", int'(rd_early), 0);
      din = 16'hBEEF; tick(); din_valid = 1'b0;
      chk("restart_cnt1", int'(wr_count), 1);
      rd_check(0, 16'hBEEF, "restart_addr0");

      // Full load with din = index
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         din = 16'(i); din_valid = 1'b1;
         if (i == 255) chk("loaded_before_last", int'(loaded), 0);
         tick();
      end
      din_valid = 1'b0;
      chk("full_loaded", int'(loaded), 1);
      chk("full_cnt", int'(wr_count), 256);
      rd_check(5, 5, "rd5");
      rd_check(255, 255, "rd255");

      // No accept in FULL; 0xFFFF must not land at address 0
      din = 16'hFFFF; din_valid = 1'b1;
      repeat (10) tick();
      din_valid = 1'b0;
      chk("full_hold_cnt", int'(wr_count), 256);
      rd_check(0, 0, "full_no_overwrite");

      // Streaming readback 0..255, contiguous outputs
      for (int k = 0; k < 256 + LAT - 1; k++) begin
         rd_addr_valid = (k < 256);
         rd_addr = 8'(k);
         tick();
         if (k - (LAT - 1) >= 0) begin
            chk("stream_dv", int'(dout_valid), 1);
            chk("stream_dout", int'(dout), k - (LAT - 1));
         end
      end
      rd_addr_valid = 1'b0;
      tick();
      chk("stream_end_dv", int'(dout_valid), 0);

      // Collision: write 0x1234 to addr 0 while reading it, then read again
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      chk("reload_loaded", int'(loaded), 0);
      chk("reload_cnt", int'(wr_count), 0);
      for (int k = 0; k <= LAT; k++) begin
         din = 16'h1234;
         din_valid = (k == 0);
         rd_addr = 8'd0;
         rd_addr_valid = (k < 2);
         tick();
         if (k - (LAT - 1) == 0) chk("coll_old", int'(dout), 0);
         if (k - (LAT - 1) == 1) chk("coll_new", int'(dout), 16'h1234);
      end
      rd_addr_valid = 1'b0; din_valid = 1'b0;

      // Load to count 50, then reset with reads in flight
      for (int i = 1; i < 50; i++) begin
         din = 16'(i + 16'h100); din_valid = 1'b1;
         tick();
      end
      chk("cnt50", int'(wr_count), 50);
      rd_addr = 8'd7; rd_addr_valid = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_dv", int'(dout_valid), 0);
      chk("mid_rst_dout", int'(dout), 0);
      chk("mid_rst_cnt", int'(wr_count), 0);
      chk("mid_rst_loaded", int'(loaded), 0);
      chk("mid_rst_early", int'(rd_early), 0);
      chk("mid_rst_ready", int'(din_ready), 0);
      rd_addr_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_idle_cnt", int'(wr_count), 0);
      chk("post_rst_idle_dv", int'(dout_valid), 0);
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      din = 16'h0055; tick(); din_valid = 1'b0;
      chk("post_rst_load", int'(wr_count), 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
